toggle_ram_ctrl: RTL and testbench

- Parametrised successor to the single-channel toggle-enabled stack RAM used by generated FSM+datapath modules.
- Serves NUM_CH independent requesters against one single-port block RAM of DEPTH words.
- Each requester uses a toggle handshake; a round-robin arbiter grants one channel at a time.
- All logic on the rising edge only: no negedge RAM process. Byte addressing, byte-enable writes and per-channel read-data registers.

---
 rtl/toggle_ram_pkg.sv | 29 ++
 rtl/toggle_ram_ctrl_if.sv | 37 +++
 rtl/toggle_ram_ctrl_rr_arbiter.sv | 42 ++++
 rtl/toggle_ram_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_toggle_ram_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/toggle_ram_pkg.sv
// Shared types and constant helpers for the toggle-handshake RAM controller.
// Optional feature macro used by the controller: TOGGLE_RAM_BOUNDS_CHECK_EN.
package toggle_ram_pkg;

  // Controller FSM: one idle/grant cycle followed by one access cycle.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Index width for an n-entry table, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : clog2_f(n);
  endfunction

  // Number of byte-offset bits dropped from a byte address to form a word address.
  function automatic int byte_shift(input int width);
    return clog2_f(width / 8);
  endfunction

endpackage

// File: rtl/toggle_ram_ctrl_if.sv
// Requester bus of the toggle-handshake RAM controller, all channels packed flat.
// The err vector exists only when TOGGLE_RAM_BOUNDS_CHECK_EN is defined.
interface toggle_ram_ctrl_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32,
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0]          req_tgl;
  logic [NUM_CH-1:0]          wr_en;
  logic [NUM_CH*ADDR_W-1:0]   addr;
  logic [NUM_CH*WIDTH-1:0]    wdata;
  logic [NUM_CH*WIDTH/8-1:0]  be;
  logic [NUM_CH-1:0]          ack_tgl;
  logic [NUM_CH*WIDTH-1:0]    rdata;
  logic                       busy;
`ifdef TOGGLE_RAM_BOUNDS_CHECK_EN
  logic [NUM_CH-1:0]          err;
`endif

  // Requester side.
  modport master (
    output req_tgl, wr_en, addr, wdata, be,
    input  ack_tgl, rdata, busy
`ifdef TOGGLE_RAM_BOUNDS_CHECK_EN
    , input err
`endif
  );

  // Controller side.
  modport slave (
    input  req_tgl, wr_en, addr, wdata, be,
    output ack_tgl, rdata, busy
`ifdef TOGGLE_RAM_BOUNDS_CHECK_EN
    , output err
`endif
  );
endinterface

// File: rtl/toggle_ram_ctrl_rr_arbiter.sv
// Round-robin arbiter: search starts at the channel after the last grant;
// the pointer only moves when the grant is actually taken (advance).
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);
  logic [IW-1:0] ptr_reg;

  // First requesting channel at or after the pointer, wrapping around.
  always_comb begin
    int cand;
    cand    = 0;
    any     = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr_reg) + i;
      if (cand >= N) cand = cand - N;
      if (!any && req[cand]) begin
        any     = 1'b1;
        gnt_idx = IW'(cand);
      end
    end
    gnt = any ? (N'(1) << gnt_idx) : '0;
  end

  // Pointer moves to the channel after the one just granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg <= '0;
    end else if (advance) begin
      ptr_reg <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end
endmodule

// File: rtl/toggle_ram_ctrl.sv
// Multi-channel toggle-handshake controller in front of one single-port RAM.
// Optional TOGGLE_RAM_BOUNDS_CHECK_EN: out-of-range accesses are suppressed
// (reads return 0) and flag a sticky per-channel err bit; otherwise they wrap.
module toggle_ram_ctrl
  import toggle_ram_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int NUM_CH = 2
) (
  input logic              clk,
  input logic              reset,
  toggle_ram_ctrl_if.slave bus
);
  localparam int NB    = WIDTH / 8;
  localparam int SHIFT = byte_shift(WIDTH);
  localparam int IDX_W = idx_width(DEPTH);
  localparam int CH_W  = idx_width(NUM_CH);

  state_t            state_reg, state_next;
  logic              ack_bit   [NUM_CH];
  logic [WIDTH-1:0]  rdata_reg [NUM_CH];
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] arb_gnt;
  logic [CH_W-1:0]   arb_idx;
  logic              arb_any;

  logic              access_busy, grant_fire, complete, ram_we;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr, word_full;
  logic [WIDTH-1:0]  sel_wdata;
  logic [NB-1:0]     sel_be;
  logic [IDX_W-1:0]  word_next;

  logic [CH_W-1:0]   gnt_reg;
  logic              wr_reg;
  logic [IDX_W-1:0]  word_reg;
  logic [WIDTH-1:0]  wdata_reg;
  logic [NB-1:0]     be_reg;
  logic [WIDTH-1:0]  ram_q, rd_word;

  (* ram_style = "block" *) logic [WIDTH-1:0] ram [DEPTH];

  rr_arbiter #(.N(NUM_CH), .IW(CH_W)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (pending),
    .advance (grant_fire),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next state: grant cycle then exactly one access cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (arb_any) state_next = ACCESS;
      ACCESS:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: grant strobe in IDLE, completion strobe and busy in ACCESS.
  always_comb begin
    access_busy = 1'b0;
    grant_fire  = 1'b0;
    complete    = 1'b0;
    case (state_reg)
      IDLE:   grant_fire = arb_any;
      ACCESS: begin
        access_busy = 1'b1;
        complete    = 1'b1;
      end
      default: ;
    endcase
  end

  // Route the granted channel's request fields using the one-hot grant.
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (arb_gnt[c]) begin
        sel_wr    = bus.wr_en[c];
        sel_addr  = bus.addr[c*ADDR_W +: ADDR_W];
        sel_wdata = bus.wdata[c*WIDTH +: WIDTH];
        sel_be    = bus.be[c*NB +: NB];
      end
    end
  end

  assign word_full = sel_addr >> SHIFT;

`ifdef TOGGLE_RAM_BOUNDS_CHECK_EN
  logic              word_oob;
  logic              oob_reg;
  logic [NUM_CH-1:0] err_bit;

  // Out-of-range words park the RAM index at 0; the access itself is squashed.
  assign word_oob  = (word_full >= ADDR_W'(DEPTH));
  assign word_next = word_oob ? '0 : word_full[IDX_W-1:0];
  assign ram_we    = complete && wr_reg && !oob_reg;
  assign rd_word   = oob_reg ? '0 : ram_q;
  assign bus.err   = err_bit;

  // Remember whether the latched access is out of range.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          oob_reg <= 1'b0;
    else if (grant_fire) oob_reg <= word_oob;
  end
`else
  // Out-of-range words wrap modulo DEPTH.
  assign word_next = IDX_W'(word_full % ADDR_W'(DEPTH));
  assign ram_we    = complete && wr_reg;
  assign rd_word   = ram_q;
`endif

  // Latch the granted request for the access cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_reg   <= '0;
      wr_reg    <= 1'b0;
      word_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
    end else if (grant_fire) begin
      gnt_reg   <= arb_idx;
      wr_reg    <= sel_wr;
      word_reg  <= word_next;
      wdata_reg <= sel_wdata;
      be_reg    <= sel_be;
    end
  end

  // RAM port: registered read on the grant edge, byte-masked write on the access edge.
  always_ff @(posedge clk) begin
    if (grant_fire) ram_q <= ram[word_next];
    if (ram_we) begin
      for (int b = 0; b < NB; b++) begin
        if (be_reg[b]) ram[word_reg][b*8 +: 8] <= wdata_reg[b*8 +: 8];
      end
    end
  end

  assign bus.busy = access_busy;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign pending[gi]                   = bus.req_tgl[gi] ^ ack_bit[gi];
    assign bus.ack_tgl[gi]               = ack_bit[gi];
    assign bus.rdata[gi*WIDTH +: WIDTH]  = rdata_reg[gi];

    // Completion: flip this channel's ack and capture read data.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ack_bit[gi]   <= 1'b0;
        rdata_reg[gi] <= '0;
      end else if (complete && gnt_reg == CH_W'(gi)) begin
        ack_bit[gi] <= ~ack_bit[gi];
        if (!wr_reg) rdata_reg[gi] <= rd_word;
      end
    end

`ifdef TOGGLE_RAM_BOUNDS_CHECK_EN
    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                          err_bit[gi] <= 1'b0;
      else if (complete && gnt_reg == CH_W'(gi) && oob_reg) err_bit[gi] <= 1'b1;
    end
`endif
  end
endmodule

// File: tb/tb_toggle_ram_ctrl.sv
// Self-checking bench for toggle_ram_ctrl: directed steps then random batches,
// checked against a transaction-level model (word array + round-robin order).
module tb_toggle_ram_ctrl;
  localparam int W  = 32;
  localparam int DP = 3;
  localparam int AW = 32;
  localparam int NC = 3;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  toggle_ram_ctrl_if #(.WIDTH(W), .ADDR_W(AW), .NUM_CH(NC)) bus ();

  toggle_ram_ctrl #(.WIDTH(W), .DEPTH(DP), .ADDR_W(AW), .NUM_CH(NC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [W-1:0]  mem_m [DP];
  logic [W-1:0]  rd_m  [NC];
  logic [NC-1:0] ack_m, req_m, err_m;
  int            ptr_m;

  // Per-channel stimulus.
  logic          st_wr    [NC];
  logic [AW-1:0] st_addr  [NC];
  logic [W-1:0]  st_wdata [NC];
  logic [3:0]    st_be    [NC];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ack_m = '0; req_m = '0; err_m = '0; ptr_m = 0;
    for (int c = 0; c < NC; c++) rd_m[c] = '0;
  endtask

  task automatic set_ch(input int c, input logic wr, input logic [AW-1:0] a,
                        input logic [W-1:0] d, input logic [3:0] b);
    st_wr[c] = wr; st_addr[c] = a; st_wdata[c] = d; st_be[c] = b;
  endtask

  function automatic int next_rr(input logic [NC-1:0] m);
    for (int i = 0; i < NC; i++) begin
      int cand = (ptr_m + i) % NC;
      if (m[cand]) return cand;
    end
    return 0;
  endfunction

  // Apply one completed access to the model, in the order it is served.
  task automatic model_apply(input int c);
    int wi;
    bit oob;
    wi  = int'(st_addr[c] >> 2);
    oob = (wi >= DP);
    ack_m[c] = ~ack_m[c];
    ptr_m    = (c + 1) % NC;
`ifdef TOGGLE_RAM_BOUNDS_CHECK_EN
    if (oob) err_m[c] = 1'b1;
`else
    wi  = wi % DP;
    oob = 1'b0;
`endif
    if (st_wr[c]) begin
      if (!oob)
        for (int b = 0; b < 4; b++)
          if (st_be[c][b]) mem_m[wi][8*b +: 8] = st_wdata[c][8*b +: 8];
    end else begin
      rd_m[c] = oob ? '0 : mem_m[wi];
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack"}, 64'(bus.ack_tgl), 64'(ack_m));
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    for (int c = 0; c < NC; c++)
      check({tag, "_rdata"}, 64'(bus.rdata[c*W +: W]), 64'(rd_m[c]));
`ifdef TOGGLE_RAM_BOUNDS_CHECK_EN
    check({tag, "_err"}, 64'(bus.err), 64'(err_m));
`endif
  endtask

  // Toggle every channel in mask together, then follow each completion.
  task automatic run_batch(input logic [NC-1:0] mask);
    logic [NC-1:0] left;
    int c;
    @(negedge clk);
    for (int k = 0; k < NC; k++) begin
      bus.wr_en[k]          = st_wr[k];
      bus.addr[k*AW +: AW]  = st_addr[k];
      bus.wdata[k*W +: W]   = st_wdata[k];
      bus.be[k*4 +: 4]      = st_be[k];
    end
    req_m       = req_m ^ mask;
    bus.req_tgl = req_m;
    left        = mask;
    while (left != '0) begin
      c = next_rr(left);
      @(posedge clk); @(negedge clk);
      check("busy_grant", 64'(bus.busy), 64'd1);
      check("ack_hold", 64'(bus.ack_tgl), 64'(ack_m));
      @(posedge clk); @(negedge clk);
      model_apply(c);
      left[c] = 1'b0;
      check_idle_outputs("done");
      $display("txn ch=%0d %s addr=0x%08h wdata=0x%08h be=%b ack=%b rdata=0x%08h",
               c, st_wr[c] ? "WR" : "RD", st_addr[c], st_wdata[c], st_be[c],
               bus.ack_tgl, bus.rdata[c*W +: W]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b0;
    bus.req_tgl = '0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    check_idle_outputs("rst");
  endtask

  initial begin
    logic [W-1:0] word0_before;
    reset       = 1'b0;
    bus.req_tgl = '0;
    bus.wr_en   = '0;
    bus.addr    = '0;
    bus.wdata   = '0;
    bus.be      = '0;
    for (int c = 0; c < NC; c++) set_ch(c, 1'b0, '0, '0, 4'h0);
    model_reset();
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;

    // Fill every word so no read sees uninitialised RAM.
    for (int i = 1; i < DP; i++) begin
      set_ch(0, 1'b1, AW'(4 * i), $urandom, 4'hF);
      run_batch(3'b001);
    end
    set_ch(0, 1'b1, 32'd0, 32'd3, 4'hF);
    run_batch(3'b001);
    set_ch(0, 1'b0, 32'd0, 32'd0, 4'hF);
    run_batch(3'b001);
    check("single_read3", 64'(bus.rdata[0 +: W]), 64'd3);

    // Reset lands while a write of 9 to word 0 is in its access cycle.
    set_ch(0, 1'b1, 32'd0, 32'd9, 4'hF);
    @(negedge clk);
    bus.wr_en[0] = 1'b1; bus.addr[0 +: AW] = '0; bus.wdata[0 +: W] = 32'd9; bus.be[0 +: 4] = 4'hF;
    bus.req_tgl = 3'b001;
    @(posedge clk); @(negedge clk);
    check("midrst_busy_before", 64'(bus.busy), 64'd1);
    reset       = 1'b0;
    bus.req_tgl = '0;
    model_reset();
    #1;
    check("midrst_ack", 64'(bus.ack_tgl), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    set_ch(0, 1'b0, 32'd0, 32'd0, 4'hF);
    run_batch(3'b001);
    check("midrst_read3", 64'(bus.rdata[0 +: W]), 64'd3);

    // Two channels on one cycle from a fresh pointer: write then read of word 1.
    do_reset();
    set_ch(0, 1'b1, 32'd4, 32'd6, 4'hF);
    set_ch(1, 1'b0, 32'd4, 32'd0, 4'h0);
    run_batch(3'b011);
    check("two_ch_read6", 64'(bus.rdata[W +: W]), 64'd6);
    set_ch(0, 1'b0, 32'd4, 32'd0, 4'h0);
    run_batch(3'b001);
    set_ch(1, 1'b0, 32'd0, 32'd0, 4'h0);
    run_batch(3'b011);

    // Byte enables on word 2.
    set_ch(2, 1'b1, 32'd8, 32'hAABBCCDD, 4'hF);
    run_batch(3'b100);
    set_ch(2, 1'b1, 32'd8, 32'h11223344, 4'b0101);
    run_batch(3'b100);
    set_ch(2, 1'b0, 32'd8, 32'd0, 4'h0);
    run_batch(3'b100);
    check("byte_en_merge", 64'(bus.rdata[2*W +: W]), 64'hAA22CC44);

    // Misaligned byte address 5 aliases word 1.
    set_ch(2, 1'b0, 32'd5, 32'd0, 4'h0);
    run_batch(3'b100);
    check("misaligned_read", 64'(bus.rdata[2*W +: W]), 64'd6);

    // be=0 write is a no-op but still acknowledged.
    set_ch(1, 1'b1, 32'd4, 32'hFFFFFFFF, 4'h0);
    run_batch(3'b010);
    set_ch(1, 1'b0, 32'd4, 32'd0, 4'h0);
    run_batch(3'b010);
    check("be_zero_noop", 64'(bus.rdata[W +: W]), 64'd6);

    // First out-of-range word: suppressed with bounds checking, wraps to word 0 otherwise.
    word0_before = mem_m[0];
    set_ch(1, 1'b1, AW'(DP * 4), 32'h5A5A0001, 4'hF);
    run_batch(3'b010);
    set_ch(1, 1'b0, 32'd0, 32'd0, 4'h0);
    run_batch(3'b010);
`ifdef TOGGLE_RAM_BOUNDS_CHECK_EN
    check("oob_word0", 64'(bus.rdata[W +: W]), 64'(word0_before));
    check("oob_err", 64'(bus.err[1]), 64'd1);
`else
    check("oob_wrap_word0", 64'(bus.rdata[W +: W]), 64'h5A5A0001);
`endif

    // Random batches over all channels, including out-of-range addresses.
    for (int n = 0; n < 40; n++) begin
      for (int c = 0; c < NC; c++)
        set_ch(c, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DP * 4 + 7)),
               $urandom, 4'($urandom_range(0, 15)));
      run_batch(NC'($urandom_range(1, (1 << NC) - 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
